riscv_li_encoder: RTL

RISCV_LI_ENCODER -- requirements
Module: riscv_li_encoder

---
 rtl/riscv_isa_pkg.sv | 21 ++
 rtl/riscv_utype_pack.sv | 11 +
 rtl/riscv_li_encoder.sv | 114 +++++++++++
 3 files changed

// File: rtl/riscv_isa_pkg.sv
// rtl/riscv_isa_pkg.sv - RV32I opcode constants and li-encoder state type
package riscv_isa_pkg;

  localparam logic [6:0]  OPC_LUI     = 7'h37;
  localparam logic [6:0]  OPC_AUIPC   = 7'h17;
  localparam logic [6:0]  OPC_OPIMM   = 7'h13;
  localparam logic [2:0]  FUNCT3_ADDI = 3'b000;
  localparam logic [31:0] NOP_INST    = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT_U = 2'd1,
    EMIT_I = 2'd2
  } li_state_t;

  function automatic logic [31:0] addi_word(input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [11:0] imm);
    return {imm, rs1, FUNCT3_ADDI, rd, OPC_OPIMM};
  endfunction

endpackage

// File: rtl/riscv_utype_pack.sv
// rtl/riscv_utype_pack.sv - packs a U-type instruction word from its fields
module riscv_utype_pack (
  input  logic [19:0] imm20,
  input  logic [4:0]  rd,
  input  logic [6:0]  opcode,
  output logic [31:0] inst
);

  assign inst = {imm20, rd, opcode};

endmodule

// File: rtl/riscv_li_encoder.sv
// rtl/riscv_li_encoder.sv - expands a load-immediate/PC-relative request into LUI/AUIPC + ADDI words
module riscv_li_encoder
  import riscv_isa_pkg::*;
#(
  parameter bit OPT_SKIP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_value,
  input  logic        in_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_last
);

  li_state_t   state_q, state_d;
  logic        out_valid_d, out_last_d;
  logic [31:0] out_inst_d;
  logic [31:0] addi_q, addi_d;

  logic [11:0] lo;
  logic [19:0] hi;
  logic [31:0] u_word;
  logic        fits_imm12;
  logic        addi_owed;
  logic        handshake;

  // Adding bit 11 to the upper field compensates for ADDI sign-extending lo.
  assign lo         = in_value[11:0];
  assign hi         = in_value[31:12] + {19'd0, in_value[11]};
  assign fits_imm12 = (in_value[31:11] == {21{in_value[11]}});
  assign addi_owed  = !(OPT_SKIP && (lo == 12'd0));

  riscv_utype_pack u_pack (
    .imm20  (hi),
    .rd     (in_rd),
    .opcode (in_mode ? OPC_AUIPC : OPC_LUI),
    .inst   (u_word)
  );

  assign in_ready  = (state_q == IDLE) && !rst;
  assign handshake = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid;
    out_last_d  = out_last;
    out_inst_d  = out_inst;
    addi_d      = addi_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          out_valid_d = 1'b1;
          if (in_rd == 5'd0) begin
            out_inst_d = NOP_INST;
            out_last_d = 1'b1;
            state_d    = EMIT_I;
          end else if (!in_mode && OPT_SKIP && fits_imm12) begin
            out_inst_d = addi_word(in_rd, 5'd0, lo);
            out_last_d = 1'b1;
            state_d    = EMIT_I;
          end else begin
            out_inst_d = u_word;
            out_last_d = !addi_owed;
            addi_d     = addi_word(in_rd, in_rd, lo);
            state_d    = EMIT_U;
          end
        end
      end
      EMIT_U: begin
        if (handshake) begin
          if (out_last) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = IDLE;
          end else begin
            out_inst_d = addi_q;
            out_last_d = 1'b1;
            state_d    = EMIT_I;
          end
        end
      end
      EMIT_I: begin
        if (handshake) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_inst  <= 32'h0;
      addi_q    <= 32'h0;
    end else begin
      state_q   <= state_d;
      out_valid <= out_valid_d;
      out_last  <= out_last_d;
      out_inst  <= out_inst_d;
      addi_q    <= addi_d;
    end
  end

endmodule
